// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment digit decoder.
// Holds the active-high segment table, the all-off/all-lit constants,
// the segment-index enum and a polarity helper used by the top.
// No ports (package).
package seven_seg_pkg;

    // Segment bit positions inside a 7-bit pattern.
    typedef enum logic [2:0] {
        SEG_A = 3'd0,
        SEG_B = 3'd1,
        SEG_C = 3'd2,
        SEG_D = 3'd3,
        SEG_E = 3'd4,
        SEG_F = 3'd5,
        SEG_G = 3'd6
    } seg_idx_e;

    localparam logic [6:0] SEG_OFF_AH = 7'h00;
    localparam logic [6:0] SEG_ALL_AH = 7'h7F;

    // Active-high glyphs for 0-9, A, b, C, d, E, F (1 = segment lit).
    localparam logic [6:0] SEG_TABLE_AH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Convert an active-high pattern to the drive polarity of the display.
    function automatic logic [6:0] seg_drive(input logic [6:0] ah, input bit active_low);
        return active_low ? ~ah : ah;
    endfunction

endpackage

// File: rtl/seven_seg_decoder_lut.sv
// Combinational hex-to-segment lookup, active-high output.
// Ports:
//   nibble_i [3:0] : hex code 0x0-0xF
//   seg_o    [6:0] : active-high segment pattern, bit0 = seg a ... bit6 = seg g
module seven_seg_lut
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_TABLE_AH[nibble_i];
    end

endmodule

// File: rtl/seven_seg_decoder.sv
// Registered hex-to-seven-segment decoder for one board display digit.
// One clock of latency from a/blank to result; result holds while en=0.
// Optional lamp test is enabled by defining SEVEN_SEG_LAMP_TEST_EN.
// Parameters:
//   ACTIVE_LOW : 1 = lit segment driven 0 (common anode), 0 = lit driven 1
// Ports:
//   clk       : system clock, rising edge
//   rst_n     : asynchronous active-low reset, forces all segments off
//   en        : load strobe
//   blank     : load all-off instead of the glyph for a
//   lamp_test : (SEVEN_SEG_LAMP_TEST_EN only) load all-lit, overrides en/blank
//   a [3:0]   : nibble to display
//   result[6:0]: segment pattern, bit0 = seg a ... bit6 = seg g
module seven_seg_decoder
    import seven_seg_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       blank,
`ifdef SEVEN_SEG_LAMP_TEST_EN
    input  logic       lamp_test,
`endif
    input  logic [3:0] a,
    output logic [6:0] result
);

    logic [6:0] glyph_ah;
    logic [6:0] result_d;
    logic [6:0] result_q;

    seven_seg_lut u_lut (
        .nibble_i (a),
        .seg_o    (glyph_ah)
    );

    // Polarity is applied before the register so the flops hold display levels.
    always_comb begin
        result_d = result_q;
`ifdef SEVEN_SEG_LAMP_TEST_EN
        if (lamp_test) begin
            result_d = seg_drive(SEG_ALL_AH, ACTIVE_LOW);
        end else
`endif
        if (en) begin
            result_d = seg_drive(blank ? SEG_OFF_AH : glyph_ah, ACTIVE_LOW);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= seg_drive(SEG_OFF_AH, ACTIVE_LOW);
        end else begin
            result_q <= result_d;
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_seven_seg_decoder.sv
module tb_seven_seg_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       blank;
    logic [3:0] a;
    logic [6:0] result_lo;
    logic [6:0] result_hi;
`ifdef SEVEN_SEG_LAMP_TEST_EN
    logic       lamp_test;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seven_seg_decoder #(.ACTIVE_LOW(1'b1)) dut_lo (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .blank     (blank),
`ifdef SEVEN_SEG_LAMP_TEST_EN
        .lamp_test (lamp_test),
`endif
        .a         (a),
        .result    (result_lo)
    );

    seven_seg_decoder #(.ACTIVE_LOW(1'b0)) dut_hi (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .blank     (blank),
`ifdef SEVEN_SEG_LAMP_TEST_EN
        .lamp_test (lamp_test),
`endif
        .a         (a),
        .result    (result_hi)
    );

    typedef struct {
        string      name;
        logic       en;
        logic       blank;
        logic [3:0] a;
        logic [6:0] exp_lo;
        logic [6:0] exp_hi;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input string name, input logic e, input logic b, input logic [3:0] n,
                       input logic [6:0] lo, input logic [6:0] hi);
        vec_t v;
        v.name = name; v.en = e; v.blank = b; v.a = n; v.exp_lo = lo; v.exp_hi = hi;
        vecs.push_back(v);
    endtask

    initial begin
        // Glyph sweep 0..F: active-low value and its inverse for ACTIVE_LOW=0.
        add("hex0", 1, 0, 4'h0, 7'h40, 7'h3F);
        add("hex1", 1, 0, 4'h1, 7'h79, 7'h06);
        add("hex2", 1, 0, 4'h2, 7'h24, 7'h5B);
        add("hex3", 1, 0, 4'h3, 7'h30, 7'h4F);
        add("hex4", 1, 0, 4'h4, 7'h19, 7'h66);
        add("hex5", 1, 0, 4'h5, 7'h12, 7'h6D);
        add("hex6", 1, 0, 4'h6, 7'h02, 7'h7D);
        add("hex7", 1, 0, 4'h7, 7'h78, 7'h07);
        add("hex8", 1, 0, 4'h8, 7'h00, 7'h7F);
        add("hex9", 1, 0, 4'h9, 7'h10, 7'h6F);
        add("hexA", 1, 0, 4'hA, 7'h08, 7'h77);
        add("hexb", 1, 0, 4'hB, 7'h03, 7'h7C);
        add("hexC", 1, 0, 4'hC, 7'h46, 7'h39);
        add("hexd", 1, 0, 4'hD, 7'h21, 7'h5E);
        add("hexE", 1, 0, 4'hE, 7'h06, 7'h79);
        add("hexF", 1, 0, 4'hF, 7'h0E, 7'h71);
        // Blank with en=0 must not load; with en=1 it loads all-off.
        add("hold_blank_en0", 0, 1, 4'h3, 7'h0E, 7'h71);
        add("blank_en1",      1, 1, 4'h3, 7'h7F, 7'h00);
        add("hold_after_blank", 0, 0, 4'h7, 7'h7F, 7'h00);
        add("load7",          1, 0, 4'h7, 7'h78, 7'h07);

        rst_n = 1'b0;
        en    = 1'b1;
        blank = 1'b0;
        a     = 4'h8;
`ifdef SEVEN_SEG_LAMP_TEST_EN
        lamp_test = 1'b0;
`endif

        // Reset held across clock edges with a valid load pending.
        tick();
        tick();
        check("reset_lo", result_lo, 7'h7F);
        check("reset_hi", result_hi, 7'h00);
        rst_n = 1'b1;
        tick();
        check("first_load_lo", result_lo, 7'h00);
        check("first_load_hi", result_hi, 7'h7F);

        // Asynchronous reset mid-cycle, no clock edge in between.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_lo", result_lo, 7'h7F);
        check("async_reset_hi", result_hi, 7'h00);
        tick();
        rst_n = 1'b1;

        // Table-driven vectors, one per cycle.
        for (int i = 0; i < vecs.size(); i++) begin
            en    = vecs[i].en;
            blank = vecs[i].blank;
            a     = vecs[i].a;
            tick();
            check({vecs[i].name, "_lo"}, result_lo, vecs[i].exp_lo);
            check({vecs[i].name, "_hi"}, result_hi, vecs[i].exp_hi);
        end

        // Hold: load 5, then drop en and change a.
        en = 1'b1; blank = 1'b0; a = 4'h5;
        tick();
        check("load5", result_lo, 7'h12);
        en = 1'b0; a = 4'h9;
        tick();
        check("hold5_a", result_lo, 7'h12);
        tick();
        check("hold5_b", result_lo, 7'h12);
        check("hold5_hi", result_hi, 7'h6D);
        en = 1'b1;
        tick();
        check("reload9", result_lo, 7'h10);

        // Blank then unblank on a=0.
        a = 4'h0; blank = 1'b1;
        tick();
        check("blank0", result_lo, 7'h7F);
        blank = 1'b0;
        tick();
        check("unblank0", result_lo, 7'h40);

        // Active-high instance, a=1.
        a = 4'h1;
        tick();
        check("ah_one", result_hi, 7'h06);

`ifdef SEVEN_SEG_LAMP_TEST_EN
        // Lamp test overrides en=0 and blank=1, then holds until next load.
        en = 1'b0; blank = 1'b1; lamp_test = 1'b1;
        tick();
        check("lamp_lo", result_lo, 7'h00);
        check("lamp_hi", result_hi, 7'h7F);
        lamp_test = 1'b0;
        tick();
        check("lamp_hold_a", result_lo, 7'h00);
        tick();
        check("lamp_hold_b", result_lo, 7'h00);
        en = 1'b1; blank = 1'b0; a = 4'h3;
        tick();
        check("lamp_reload", result_lo, 7'h30);
        // Lamp test also beats en=1 with blank=1.
        blank = 1'b1; lamp_test = 1'b1;
        tick();
        check("lamp_vs_blank", result_lo, 7'h00);
        lamp_test = 1'b0;
        tick();
        check("blank_after_lamp", result_lo, 7'h7F);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seven_seg_decoder.md
Name: seven_seg_decoder

Overview:
Registered hex-to-seven-segment decoder driving one digit of the board display (the DHEX0..DHEX2 and THEX digits). It converts a 4-bit nibble (0-F) into a 7-bit segment pattern with one clock of latency. Narrower sources such as the 2-bit time counter are zero-extended by the caller. Output polarity is parameterised; the default is active-low for common-anode board displays.

Parameters:
ACTIVE_LOW, 1, 1 = a lit segment is driven 0 (board default); 0 = a lit segment is driven 1.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
rst_n  input  1  asynchronous, active-low reset.
en  input  1  load enable; result updates only when en=1.
blank  input  1  when 1, the digit shows all segments off, regardless of a.
a  input  4  nibble to display, 0x0-0xF.
result  output  7  segment pattern; bit0=seg a, bit1=b, bit2=c, bit3=d, bit4=e, bit5=f, bit6=g.

Behaviour:
- Reset is asynchronous and active-low: while rst_n=0, result is all segments off (7'h7F when ACTIVE_LOW=1, 7'h00 when 0). Reset mid-operation blanks the digit immediately, without waiting for a clock edge.
- Latency is 1 cycle. On the rising clk edge with en=1, result <= pattern(a, blank). With en=0, result holds its value.
- blank has priority over a. blank=1 with en=1 loads all-off on the next edge.
- Active-low patterns (ACTIVE_LOW=1), hex values:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- ACTIVE_LOW=0: result is the bitwise inverse of the table above, including the blank and reset values.
- Letters are A, b, C, d, E, F so that b and d are distinguishable from 8 and 0.
- The decode is total over all 16 codes. No X is propagated for any defined input.
- No handshake: en is a plain load strobe, and back-to-back loads are allowed every cycle.
- No internal state besides the 7-bit output register.

Optional Feature:
Macro SEVEN_SEG_LAMP_TEST_EN.
- Defined:
  - Adds input lamp_test (1 bit).
  - On a clock edge with lamp_test=1, result loads all segments lit (7'h00 when active-low), regardless of en, blank and a.
  - Priority: reset > lamp_test > en/blank > hold.
- Undefined: the port does not exist and the behaviour is exactly as in the Behaviour section.

Decomposition:
- Package seven_seg_pkg holds:
  - the 16-entry active-high segment table as a localparam array;
  - constants SEG_OFF_AH=7'h00 and SEG_ALL_AH=7'h7F;
  - a segment-index enum (SEG_A..SEG_G = 0..6).
- One combinational sub-module, seven_seg_lut: 4-bit nibble in, active-high 7-bit pattern out.
- The top applies blank, lamp test, polarity inversion and the output register.

Test Plan:
1. Hold rst_n=0 with a=8, en=1, then release rst_n → result=7F while in reset. After release, on the first clock edge result=00. rst_n asserted mid-cycle forces result to 7F without a clock edge.
2. Sweep a=0..F with en=1, one value per cycle → each result matches the table one cycle later (e.g. a=2 gives 24, a=b gives 03, a=F gives 0E).
3. Load a=5 (result=12), then drop en and change a to 9 → result stays at 12 until en returns.
4. Set a=0 and blank=1 with en=1 → result=7F next cycle. Clear blank → result=40 on the following cycle.
5. Build with ACTIVE_LOW=0 and set a=1 → result=06. Reset gives result=00.
6. With SEVEN_SEG_LAMP_TEST_EN defined: lamp_test=1 while en=0 and blank=1 → result=00. Release lamp_test → result holds 00 until the next en load.
